// File: rtl/grf_bypass_if.sv
// -----------------------------------------------------------------------------
// grf_bypass_if
// Bundle of writeback-side write signals and decode-side read signals for the
// general register file.
//   RegWrite / WriteA / WD / WPC : write request from WB (master -> slave)
//   RA1 / RA2                    : read addresses from ID (master -> slave)
//   RD1 / RD2                    : read data back to ID (slave -> master)
//   wr_count                     : effective-write counter (slave -> master)
// -----------------------------------------------------------------------------
interface grf_bypass_if #(
    parameter int DATA_W = 32
);
    logic              RegWrite;
    logic [4:0]        WriteA;
    logic [DATA_W-1:0] WD;
    logic [31:0]       WPC;
    logic [4:0]        RA1;
    logic [4:0]        RA2;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic [31:0]       wr_count;

    modport master (
        output RegWrite, WriteA, WD, WPC, RA1, RA2,
        input  RD1, RD2, wr_count
    );

    modport slave (
        input  RegWrite, WriteA, WD, WPC, RA1, RA2,
        output RD1, RD2, wr_count
    );
endinterface

// File: rtl/grf_bypass.sv
// -----------------------------------------------------------------------------
// grf_bypass
// 31-entry general register file ($0 reads as zero, has no storage) with two
// combinational read ports and an optional same-cycle write-to-read bypass.
// Also counts effective writes (RegWrite with a non-zero destination).
//
// Ports:
//   clk    : rising-edge clock for all state
//   reset  : asynchronous, active-low; clears registers and wr_count at once
//   bus    : grf_bypass_if.slave (write request, read addresses/data, count)
//
// Parameters:
//   DATA_W : register width
//   BYPASS : 1 forwards the write data of the current cycle to matching reads
//
// Optional feature macro: GRF_WRITE_TRACE_EN
//   When defined, one trace line is printed for every effective write edge.
// -----------------------------------------------------------------------------
module grf_bypass #(
    parameter int DATA_W = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    grf_bypass_if.slave   bus
);

    logic [DATA_W-1:0] r_regs [1:31];
    logic [31:0]       r_wr_count;
    logic              w_weff;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // Writes to $0 are discarded entirely: no storage, no count, no trace.
    assign w_weff = bus.RegWrite && (bus.WriteA != 5'd0);

    // Register array update; reset wins over a write in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_weff) begin
            r_regs[bus.WriteA] <= bus.WD;
        end
    end

    // Effective-write counter; wraps silently through zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_count <= 32'd0;
        end else if (w_weff) begin
            r_wr_count <= r_wr_count + 32'd1;
        end
    end

`ifdef GRF_WRITE_TRACE_EN
    // Per-write trace, printed only for edges that actually write.
    always_ff @(posedge clk) begin
        if (reset && w_weff) begin
            $display("%d@%h: $%d <= %h", $time, bus.WPC, bus.WriteA, bus.WD);
        end
    end
`else
    // The trace PC has no other consumer.
    logic w_unused_wpc;
    assign w_unused_wpc = ^bus.WPC;
`endif

    // Read port 1: $0 first, then bypass, then stored value.
    always_comb begin
        w_rd1 = '0;
        if (bus.RA1 == 5'd0) begin
            w_rd1 = '0;
        end else if (BYPASS && w_weff && (bus.WriteA == bus.RA1)) begin
            w_rd1 = bus.WD;
        end else begin
            w_rd1 = r_regs[bus.RA1];
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        w_rd2 = '0;
        if (bus.RA2 == 5'd0) begin
            w_rd2 = '0;
        end else if (BYPASS && w_weff && (bus.WriteA == bus.RA2)) begin
            w_rd2 = bus.WD;
        end else begin
            w_rd2 = r_regs[bus.RA2];
        end
    end

    assign bus.RD1      = w_rd1;
    assign bus.RD2      = w_rd2;
    assign bus.wr_count = r_wr_count;

endmodule
